// File: rtl/bcd_timekeeper.sv
// bcd_timekeeper: BCD time-of-day keeper with validated load, per-field adjust, 12/24 h display, day and alarm strobes
module bcd_timekeeper #(
   parameter logic [7:0] RESET_HH  = 8'h16,
   parameter logic [7:0] RESET_MM  = 8'h25,
   parameter logic [7:0] RESET_SS  = 8'h00,
   parameter int         HAS_ALARM = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       set_en,
   input  logic       set_load,
   input  logic [7:0] set_hh,
   input  logic [7:0] set_mm,
   input  logic [7:0] set_ss,
   input  logic       adj_inc,
   input  logic [1:0] adj_sel,
   input  logic       mode_12h,
   input  logic       alarm_en,
   input  logic [7:0] alarm_hh,
   input  logic [7:0] alarm_mm,
   output logic [7:0] hh,
   output logic [7:0] mm,
   output logic [7:0] ss,
   output logic [7:0] disp_hh,
   output logic       pm,
   output logic       day_tick,
   output logic       alarm_hit,
   output logic       load_err
);
   logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d, sub12;
   logic       day_q, day_d, alarm_q, alarm_d, err_q, err_d;
   logic       ld_ok, do_adj, do_cnt, c_ss, c_mm;

   function automatic logic [7:0] inc_bcd(input logic [7:0] v, input logic [7:0] top);
      return (v == top) ? 8'h00 : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
   endfunction

   always_comb begin
      ld_ok   = set_hh[3:0] <= 4'd9 && set_mm[3:0] <= 4'd9 && set_ss[3:0] <= 4'd9 &&
                set_hh <= 8'h23 && set_mm[7:4] <= 4'd5 && set_ss[7:4] <= 4'd5;
      do_adj  = set_en && adj_inc && !set_load;
      do_cnt  = tick_1hz && !set_en && !set_load;
      c_ss    = ss_q == 8'h59;
      c_mm    = c_ss && mm_q == 8'h59;
      ss_d    = set_load ? (ld_ok ? set_ss : ss_q) :
                (do_cnt || (do_adj && adj_sel == 2'b00)) ? inc_bcd(ss_q, 8'h59) : ss_q;
      mm_d    = set_load ? (ld_ok ? set_mm : mm_q) :
                ((do_cnt && c_ss) || (do_adj && adj_sel == 2'b01)) ? inc_bcd(mm_q, 8'h59) : mm_q;
      hh_d    = set_load ? (ld_ok ? set_hh : hh_q) :
                ((do_cnt && c_mm) || (do_adj && adj_sel == 2'b10)) ? inc_bcd(hh_q, 8'h23) : hh_q;
      err_d   = set_load && !ld_ok;
      day_d   = do_cnt && c_mm && hh_q == 8'h23;
      // only a count step landing on second 00 can fire, so load/adjust into the alarm time stays silent
      alarm_d = (HAS_ALARM != 0) && do_cnt && c_ss && alarm_en && hh_d == alarm_hh && mm_d == alarm_mm;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hh_q    <= RESET_HH;
         mm_q    <= RESET_MM;
         ss_q    <= RESET_SS;
         day_q   <= 1'b0;
         alarm_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         hh_q    <= hh_d;
         mm_q    <= mm_d;
         ss_q    <= ss_d;
         day_q   <= day_d;
         alarm_q <= alarm_d;
         err_q   <= err_d;
      end
   end

   // BCD subtract 12 with a borrow from the tens digit when units < 2
   assign sub12     = hh_q[3:0] >= 4'd2 ? {hh_q[7:4] - 4'd1, hh_q[3:0] - 4'd2} : {hh_q[7:4] - 4'd2, hh_q[3:0] + 4'd8};
   assign disp_hh   = !mode_12h ? hh_q : hh_q == 8'h00 ? 8'h12 : hh_q <= 8'h12 ? hh_q : sub12;
   assign pm        = hh_q >= 8'h12;
   assign hh        = hh_q;
   assign mm        = mm_q;
   assign ss        = ss_q;
   assign day_tick  = day_q;
   assign alarm_hit = alarm_q;
   assign load_err  = err_q;
endmodule
